// File: rtl/timestamp_capture.sv
// N-channel event timestamper: synchronise inputs, detect edges, latch a free-running
// timestamp per channel and queue {channel, ts} records (plus counter-rollover markers) in a FWFT FIFO.
module timestamp_capture #(
    parameter int NCH         = 2,
    parameter int TS_W        = 24,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    localparam int CH_W       = $clog2(NCH + 1),
    localparam int REC_W      = CH_W + TS_W,
    localparam int AW         = $clog2(DEPTH),
    localparam int LVL_W      = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NCH-1:0]   datain,
    input  logic [NCH-1:0]   ch_enable,
    input  logic             clear_overflow,
    output logic [REC_W-1:0] rec_data,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic             overflow,
    output logic [LVL_W-1:0] fifo_level
);

    logic [TS_W-1:0]  cnt_q;
    logic [TS_W-1:0]  cnt_d;
    logic             cnt_wrap;

    logic [NCH-1:0]   sync_q [SYNC_STAGES];
    logic [NCH-1:0]   prev_q;
    logic [NCH-1:0]   sync_last;
    logic [NCH-1:0]   edge_hit;
    logic [NCH-1:0]   detect;

    logic [NCH-1:0]   pend_q;
    logic [NCH-1:0]   pend_d;
    logic [NCH-1:0]   grant_ch;
    logic [NCH-1:0]   capture;
    logic [NCH-1:0]   drop;
    logic [TS_W-1:0]  hold_q [NCH];

    logic             marker_q;
    logic             marker_d;
    logic             grant_marker;
    logic             marker_lost;

    logic             overflow_q;
    logic             overflow_d;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic [LVL_W-1:0] count_d;
    logic             fifo_full;
    logic             pop;
    logic             can_wr;
    logic             wr_en;
    logic [REC_W-1:0] wr_data;

    assign cnt_d    = cnt_q + TS_W'(1);
    assign cnt_wrap = &cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Input synchroniser chain; prev_q holds the last synchronised value for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= datain;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        if (EDGE_MODE == 1) begin
            edge_hit = ~sync_last & prev_q;
        end else if (EDGE_MODE == 2) begin
            edge_hit = sync_last ^ prev_q;
        end else begin
            edge_hit = sync_last & ~prev_q;
        end
    end

    assign detect = edge_hit & ch_enable;

    // Marker has priority; otherwise the lowest pending channel wins the single write slot.
    always_comb begin
        grant_ch = '0;
        if (can_wr && !marker_q) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (pend_q[i]) begin
                    grant_ch    = '0;
                    grant_ch[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wr_data = {CH_W'(NCH), {TS_W{1'b0}}};
        for (int i = 0; i < NCH; i++) begin
            if (grant_ch[i]) begin
                wr_data = {CH_W'(i), hold_q[i]};
            end
        end
    end

    assign grant_marker = can_wr & marker_q;
    assign wr_en        = grant_marker | (|grant_ch);

    // A channel whose record is being written this cycle is free to take a new capture.
    assign capture = detect & ~(pend_q & ~grant_ch);
    assign drop    = detect & pend_q & ~grant_ch;
    assign pend_d  = detect | (pend_q & ~grant_ch);

    assign marker_lost = cnt_wrap & marker_q & ~grant_marker;
    assign marker_d    = cnt_wrap | (marker_q & ~grant_marker);

    assign overflow_d = (|drop) | marker_lost | (overflow_q & ~clear_overflow);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q     <= '0;
            marker_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            marker_q   <= marker_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (capture[i]) begin
                hold_q[i] <= cnt_q;
            end
        end
    end

    assign fifo_full = (count_q == LVL_W'(DEPTH));
    assign rec_valid = (count_q != '0);
    assign pop       = rec_valid & rec_ready;
    assign can_wr    = ~fifo_full | pop;

    always_comb begin
        case ({wr_en, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Record FIFO: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rec_data   = rec_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow   = overflow_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_timestamp_capture.sv
// Bench for timestamp_capture: four configurations share one stimulus stream; a record-level
// model predicts every output each cycle, and directed literal checks pin the expected records.
module tb_timestamp_capture;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] datain = 2'b00;
    logic [1:0] ch_enable = 2'b11;
    logic       clr = 1'b0;
    logic       rec_ready = 1'b0;

    wire [3:0]       rv;
    wire [3:0]       ov;
    wire [3:0][4:0]  lv;
    wire [3:0][25:0] rd;
    wire [5:0]       rd1;

    int nchk = 0;
    int nfail = 0;
    int ecnt = 0;

    assign rd[1] = {20'd0, rd1};

    initial forever #5 clk = ~clk;

    timestamp_capture #(.NCH(2), .TS_W(24), .DEPTH(16), .SYNC_STAGES(2), .EDGE_MODE(0)) dut0 (
        .clk(clk), .rstn(rstn), .datain(datain), .ch_enable(ch_enable), .clear_overflow(clr),
        .rec_data(rd[0]), .rec_valid(rv[0]), .rec_ready(rec_ready), .overflow(ov[0]), .fifo_level(lv[0]));
    timestamp_capture #(.NCH(2), .TS_W(4), .DEPTH(16), .SYNC_STAGES(2), .EDGE_MODE(0)) dut1 (
        .clk(clk), .rstn(rstn), .datain(datain), .ch_enable(ch_enable), .clear_overflow(clr),
        .rec_data(rd1), .rec_valid(rv[1]), .rec_ready(rec_ready), .overflow(ov[1]), .fifo_level(lv[1]));
    timestamp_capture #(.NCH(2), .TS_W(24), .DEPTH(16), .SYNC_STAGES(2), .EDGE_MODE(2)) dut2 (
        .clk(clk), .rstn(rstn), .datain(datain), .ch_enable(ch_enable), .clear_overflow(clr),
        .rec_data(rd[2]), .rec_valid(rv[2]), .rec_ready(rec_ready), .overflow(ov[2]), .fifo_level(lv[2]));
    timestamp_capture #(.NCH(2), .TS_W(24), .DEPTH(16), .SYNC_STAGES(2), .EDGE_MODE(1)) dut3 (
        .clk(clk), .rstn(rstn), .datain(datain), .ch_enable(ch_enable), .clear_overflow(clr),
        .rec_data(rd[3]), .rec_valid(rv[3]), .rec_ready(rec_ready), .overflow(ov[3]), .fifo_level(lv[3]));

    // Edges since reset release; the counter equals this value after each edge.
    always @(posedge clk) begin
        if (!rstn) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic at(input int n);
        while (ecnt < n) @(negedge clk);
    endtask

    function automatic bit edge_fn(input int mode, input bit nw, input bit old);
        case (mode)
            0:       return nw & !old;
            1:       return !nw & old;
            default: return nw ^ old;
        endcase
    endfunction

    // Record-level model: an input transition seen in the samples taken 2 and 3 edges ago
    // becomes a pending event stamped with the pre-edge counter value.
    int  tsw [4] = '{24, 4, 24, 24};
    int  em  [4] = '{0, 0, 2, 1};
    bit  pend [4][2];
    int  hold [4][2];
    bit  mpend [4];
    bit  movf [4];
    int  fmem [4][16];
    int  fhead [4];
    int  fcnt [4];
    logic [1:0] hist [3];
    int  mcount = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                mcount = 0;
                for (int k = 0; k < 3; k++) hist[k] = 2'b00;
                for (int j = 0; j < 4; j++) begin
                    mpend[j] = 0; movf[j] = 0; fhead[j] = 0; fcnt[j] = 0;
                    for (int c = 0; c < 2; c++) begin pend[j][c] = 0; hold[j][c] = 0; end
                end
            end else begin
                for (int j = 0; j < 4; j++) begin
                    int  mask, cur, wdat, gch;
                    bit  popm, room, wr, mgr, loss, det, gr;
                    mask = (1 << tsw[j]) - 1;
                    cur  = mcount & mask;
                    popm = (fcnt[j] > 0) && rec_ready;
                    room = (fcnt[j] < 16) || popm;
                    wr = 0; mgr = 0; gch = -1; wdat = 0; loss = 0;
                    if (room) begin
                        if (mpend[j]) begin
                            mgr = 1; wr = 1; wdat = 2 << tsw[j];
                        end else begin
                            for (int c = 0; c < 2; c++) begin
                                if (pend[j][c] && gch < 0) begin
                                    gch = c; wr = 1; wdat = (c << tsw[j]) | hold[j][c];
                                end
                            end
                        end
                    end
                    for (int c = 0; c < 2; c++) begin
                        det = ch_enable[c] && edge_fn(em[j], hist[1][c], hist[2][c]);
                        gr  = (gch == c);
                        if (det) begin
                            if (pend[j][c] && !gr) loss = 1;
                            else begin pend[j][c] = 1; hold[j][c] = cur; end
                        end else if (gr) begin
                            pend[j][c] = 0;
                        end
                    end
                    if (cur == mask) begin
                        if (mpend[j] && !mgr) loss = 1;
                        mpend[j] = 1;
                    end else if (mgr) begin
                        mpend[j] = 0;
                    end
                    if (loss)     movf[j] = 1;
                    else if (clr) movf[j] = 0;
                    if (popm) begin fhead[j] = (fhead[j] + 1) % 16; fcnt[j]--; end
                    if (wr)   begin fmem[j][(fhead[j] + fcnt[j]) % 16] = wdat; fcnt[j]++; end
                end
                hist[2] = hist[1];
                hist[1] = hist[0];
                hist[0] = datain;
                mcount++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                int ev;
                ev = (fcnt[j] > 0) ? fmem[j][fhead[j]] : 0;
                chk($sformatf("model dut%0d rec_valid e%0d", j, ecnt), int'(rv[j]), int'(fcnt[j] > 0));
                chk($sformatf("model dut%0d rec_data e%0d", j, ecnt), int'(rd[j]), ev);
                chk($sformatf("model dut%0d fifo_level e%0d", j, ecnt), int'(lv[j]), fcnt[j]);
                chk($sformatf("model dut%0d overflow e%0d", j, ecnt), int'(ov[j]), int'(movf[j]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, edge %0d", ecnt);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset rec_valid", int'(rv[0]), 0);
        chk("reset rec_data", int'(rd[0]), 0);
        chk("reset fifo_level", int'(lv[0]), 0);
        chk("reset overflow", int'(ov[0]), 0);
        #2 rstn = 1'b1;
        rec_ready = 1'b1;

        // single rising edge on ch0, first sampled at edge 10
        at(9);   datain = 2'b01;
        at(12);  chk("t1 not yet valid", int'(rv[0]), 0);
        at(13);  chk("t1 valid", int'(rv[0]), 1);
                 chk("t1 record", int'(rd[0]), 11);
                 chk("t1 level", int'(lv[0]), 1);
        at(14);  chk("t1 popped", int'(rv[0]), 0);
        at(15);  datain = 2'b00;
        at(17);  chk("t3 first marker ts4", int'(rd[1]), 32);

        // simultaneous edges on both channels
        at(19);  datain = 2'b11;
        at(23);  chk("t2 ch0 record", int'(rd[0]), 21);
        at(24);  chk("t2 ch1 record", int'(rd[0]), (1 << 24) | 21);
                 chk("t2 no overflow", int'(ov[0]), 0);
        at(27);  datain = 2'b00;

        // event coinciding with the TS_W=4 counter wrap at edge 48
        at(45);  datain = 2'b01;
        at(49);  chk("t3 marker first", int'(rd[1]), 32);
                 chk("t3 wide ts record", int'(rd[0]), 47);
        at(50);  chk("t3 event after marker", int'(rd[1]), 15);
        at(53);  datain = 2'b00;

        // 5-cycle pulse on ch1
        at(59);  datain = 2'b10;
        at(63);  chk("t5 both: rise", int'(rd[2]), (1 << 24) | 61);
                 chk("t5 falling: nothing on rise", int'(rv[3]), 0);
        at(64);  datain = 2'b00;
        at(68);  chk("t5 both: fall", int'(rd[2]), (1 << 24) | 66);
                 chk("t5 falling: fall", int'(rd[3]), (1 << 24) | 66);

        // fill the FIFO with rec_ready low, then overflow ch1
        at(79);  rec_ready = 1'b0;
        for (int e = 80; e <= 111; e++) begin
            at(e - 1);
            datain = {1'b0, (e % 2) == 0};
        end
        at(113); chk("t4 full level", int'(lv[0]), 16);
                 chk("t4 full no overflow", int'(ov[0]), 0);
        at(115); datain = 2'b10;
                 chk("t4 head stable", int'(rd[0]), 81);
        at(116); datain = 2'b00;
        at(117); datain = 2'b10;
        at(118); datain = 2'b00;
        at(119); chk("t4 held pending no overflow", int'(ov[0]), 0);
                 chk("t4 still full", int'(lv[0]), 16);
        at(121); chk("t4 second edge lost", int'(ov[0]), 1);
        at(123); rec_ready = 1'b1;
                 chk("t4 head still stable", int'(rd[0]), 81);
        at(124); chk("t4 pop+push when full", int'(lv[0]), 16);
                 chk("t4 next head", int'(rd[0]), 83);
        at(139); chk("t4 held record drains", int'(rd[0]), (1 << 24) | 117);
                 chk("t4 last level", int'(lv[0]), 1);
        at(140); chk("t4 drained", int'(rv[0]), 0);
        at(141); clr = 1'b1;
        at(142); clr = 1'b0;
                 chk("t4 overflow cleared", int'(ov[0]), 0);

        // disabled channel produces nothing
        at(149); ch_enable = 2'b01; datain = 2'b10;
        at(153); chk("enable gate a", int'(rv[0]), 0);
        at(154); chk("enable gate b", int'(rv[0]), 0);
                 datain = 2'b00;
        at(157); ch_enable = 2'b11;

        // reset with three records queued and ch0 pending
        at(159); rec_ready = 1'b0; datain = 2'b11;
        at(160); datain = 2'b00;
        at(161); datain = 2'b01;
        at(162); datain = 2'b00;
        at(163); datain = 2'b01;
        at(164); datain = 2'b00;
        at(166); chk("t6 three queued", int'(lv[0]), 3);
        #2 rstn = 1'b0;
        #1 chk("t6 async reset valid", int'(rv[0]), 0);
           chk("t6 async reset level", int'(lv[0]), 0);
           chk("t6 async reset data", int'(rd[0]), 0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        rec_ready = 1'b1;
        at(3);   chk("t6 no stale record", int'(rv[0]), 0);
                 chk("t6 level after reset", int'(lv[0]), 0);
        at(4);   datain = 2'b01;
        at(7);   chk("t6 not yet valid", int'(rv[0]), 0);
        at(8);   chk("t6 ts restarts", int'(rd[0]), 6);
                 chk("t6 valid", int'(rv[0]), 1);
        at(12);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
